fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the 9-bit single-issue core: owns the program counter, start/done handshake, branch resolution and the 2-cycle LOAD stall.
- Sits between the instruction ROM and the control decoder.
- Consumes decoder outputs Branch, Halt and MemToReg plus the ALU compare results.
- Produces ProgCtr and a commit strobe ExecEn that gates every architectural write.

Parameters:
- PC_W, 10, program counter width; program space is 2^PC_W instructions.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  clock; all state updates on its rising edge.
- Reset  input  1  reset, asynchronous, active-high.
- Start  input  1  one-cycle pulse that launches the program from address 0.
- Inst  input  9  instruction from ROM at ProgCtr; same-cycle combinational read.
- Branch  input  1  decoder: opcode is a branch (1001..1100).
- Halt  input  1  decoder: opcode is HALT.
- MemToReg  input  1  decoder: opcode is LOAD.
- AluEq  input  1  ALU compare result: equal.
- AluGt  input  1  ALU compare result: greater than.
- AluLt  input  1  ALU compare result: less than.
- ProgCtr  output  PC_W  current instruction address.
- ExecEn  output  1  current instruction commits this cycle; register and memory writes are ANDed with it.
- Busy  output  1  high in RUN or LDWAIT.
- Done  output  1  high in HALTED.
- InstCount  output  CNT_W  instructions retired since the last launch.

Behaviour:
- States: IDLE, RUN, LDWAIT, HALTED.
- Reset (async, any state, including mid-LDWAIT): state=IDLE, ProgCtr=0, flags EqF/GtF/LtF=0, InstCount=0. Resulting outputs: ExecEn=0, Busy=0, Done=0.
- IDLE:
  - ExecEn=0.
  - On Start: next state RUN, ProgCtr=0, flags cleared, InstCount=0.
  - First instruction executes in the cycle after Start.
- RUN, per cycle on the decoded Inst:
  - HALT: ExecEn=1; next state HALTED; ProgCtr holds at the HALT address; HALT counts as retired.
  - LOAD (MemToReg=1): ExecEn=0; next state LDWAIT; ProgCtr holds.
  - Branch: ExecEn=1. Taken if opcode 1100, or 1001&EqF, or 1010&GtF, or 1011&LtF.
    - Taken: ProgCtr <= branch_lut[Inst[4:0]].
    - Not taken: ProgCtr+1.
  - CMP (opcode 0111): ExecEn=1; EqF/GtF/LtF <= AluEq/AluGt/AluLt; ProgCtr+1.
  - All other opcodes: ExecEn=1; ProgCtr+1.
- LDWAIT:
  - ExecEn=1; the data-memory output is valid and is written this cycle.
  - ProgCtr+1; next state RUN.
  - A LOAD therefore costs exactly 2 cycles.
- Flags read by a branch are the registered values, so a CMP immediately followed by a branch sees that CMP's result.
- ProgCtr+1 wraps modulo 2^PC_W (max -> 0) with no other side effect.
- InstCount:
  - Increments once per retired instruction: each RUN cycle with ExecEn=1, and the LDWAIT cycle.
  - Saturates at 2^CNT_W-1.
- Start handling:
  - Ignored in RUN and LDWAIT.
  - In HALTED, Start relaunches exactly as from IDLE: Done drops the next cycle.
- Halt and Branch both asserted (illegal decode): Halt wins.
- Busy = (state==RUN)|(state==LDWAIT); Done = (state==HALTED). Both are registered-state decodes.

Decomposition:
- Shared package seq_pkg holds:
  - state enum.
  - opcode constants OP_CMP=4'b0111, OP_BEQ=4'b1001, OP_BGT=4'b1010, OP_BLT=4'b1011, OP_BR=4'b1100, OP_LOAD=4'b1110, OP_HALT=4'b1111.
  - LUT depth 32.
- Sub-module branch_lut: 32-entry combinational table. Input 5-bit index, output PC_W-bit absolute target. Entries are constants filled per program.

Test Plan:
- Reset mid-run: assert Reset while in LDWAIT at ProgCtr=5 -> immediately ProgCtr=0, Busy=0, Done=0, ExecEn=0; Start then runs from address 0.
- Straight line: Start; ADD at 0..2, HALT at 3 -> ExecEn=1 for 4 cycles, ProgCtr 0,1,2,3 then holds 3, Done=1 from cycle 5, InstCount=4.
- LOAD stall: LOAD at address 1 -> ExecEn=0 for 1 cycle then 1, ProgCtr holds 1 for 2 cycles, total 1 extra cycle, InstCount increments once for the LOAD.
- Conditional branch: CMP with AluEq=1 at 4, then BEQ index 3 (lut[3]=20) at 5 -> ProgCtr=20 next. Repeat with AluEq=0 -> ProgCtr=6.
- Wrap and illegal decode: PC_W=4, straight ADDs from 15 -> ProgCtr=0 next. Halt=1 and Branch=1 together -> HALTED, ProgCtr held.
- Restart and ignore: Start pulsed in RUN -> no effect. Start in HALTED -> ProgCtr=0, InstCount=0, flags 0, Busy=1 next cycle.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// opcode values, branch table geometry and the branch-condition helper.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LDWAIT = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam int INST_W    = 9;
  localparam int OP_W      = 4;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

  localparam logic [OP_W-1:0] OP_CMP  = 4'b0111;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_BGT  = 4'b1010;
  localparam logic [OP_W-1:0] OP_BLT  = 4'b1011;
  localparam logic [OP_W-1:0] OP_BR   = 4'b1100;
  localparam logic [OP_W-1:0] OP_LOAD = 4'b1110;
  localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

  // Branch condition against the registered compare flags.
  function automatic logic branch_taken(input logic [OP_W-1:0] op,
                                        input logic eq_f,
                                        input logic gt_f,
                                        input logic lt_f);
    return (op == OP_BR)
         | ((op == OP_BEQ) & eq_f)
         | ((op == OP_BGT) & gt_f)
         | ((op == OP_BLT) & lt_f);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the sequencer and its environment (ROM, decoder, ALU, and
// whatever consumes the commit strobe). The sequencer is the slave side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) ();

  logic              Start;
  logic [INST_W-1:0] Inst;
  logic              Branch;
  logic              Halt;
  logic              MemToReg;
  logic              AluEq;
  logic              AluGt;
  logic              AluLt;
  logic [PC_W-1:0]   ProgCtr;
  logic              ExecEn;
  logic              Busy;
  logic              Done;
  logic [CNT_W-1:0]  InstCount;

  modport master (
    output Start, Inst, Branch, Halt, MemToReg, AluEq, AluGt, AluLt,
    input  ProgCtr, ExecEn, Busy, Done, InstCount
  );

  modport slave (
    input  Start, Inst, Branch, Halt, MemToReg, AluEq, AluGt, AluLt,
    output ProgCtr, ExecEn, Busy, Done, InstCount
  );

endinterface

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch target table: 5-bit index from the branch instruction selects an
// absolute PC. Targets are program constants; unlisted slots map to the
// index itself so a stray branch lands somewhere deterministic.
module fetch_sequencer_branch_lut
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [LUT_IDX_W-1:0] i_idx,
  output logic [PC_W-1:0]      o_target
);

  // Constant lookup; targets wider than PC_W are truncated to the program space.
  always_comb begin
    o_target = PC_W'(i_idx);
    case (i_idx)
      5'd0:    o_target = PC_W'(0);
      5'd1:    o_target = PC_W'(8);
      5'd2:    o_target = PC_W'(12);
      5'd3:    o_target = PC_W'(20);
      5'd4:    o_target = PC_W'(32);
      5'd5:    o_target = PC_W'(2);
      5'd6:    o_target = PC_W'(40);
      5'd7:    o_target = PC_W'(64);
      default: o_target = PC_W'(i_idx);
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 9-bit single-issue core. Owns the program counter,
// the start/done handshake, branch resolution with registered compare flags,
// the two-cycle LOAD stall and the retired-instruction counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for Start after reset, nothing commits
// ST_RUN    | executing the instruction at ProgCtr
// ST_LDWAIT | second cycle of a LOAD, memory data is written this cycle
// ST_HALTED | HALT retired, ProgCtr parked on it, Start relaunches
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  fetch_sequencer_if.slave bus
);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_eq_f;
  logic             r_gt_f;
  logic             r_lt_f;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [OP_W-1:0]  w_op;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_target;
  logic             w_taken;
  logic             w_exec_en;

  assign w_op     = bus.Inst[INST_W-1 -: OP_W];
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_taken  = branch_taken(w_op, r_eq_f, r_gt_f, r_lt_f);

  fetch_sequencer_branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .i_idx    (bus.Inst[LUT_IDX_W-1:0]),
    .o_target (w_target)
  );

  // Commit strobe: depends on the instruction presented this cycle, so it
  // cannot be registered; a LOAD withholds commit until its LDWAIT cycle.
  // Halt outranks a simultaneous MemToReg, matching the FSM priority.
  always_comb begin
    w_exec_en = 1'b0;
    case (r_state)
      ST_RUN:    w_exec_en = bus.Halt | ~bus.MemToReg;
      ST_LDWAIT: w_exec_en = 1'b1;
      default:   w_exec_en = 1'b0;
    endcase
  end

  // Sequencer FSM with PC, flags, retire counter and status flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_eq_f  <= 1'b0;
      r_gt_f  <= 1'b0;
      r_lt_f  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_exec_en && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (bus.Start) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_eq_f  <= 1'b0;
            r_gt_f  <= 1'b0;
            r_lt_f  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end

        ST_RUN: begin
          if (bus.Halt) begin
            r_state <= ST_HALTED;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (bus.MemToReg) begin
            r_state <= ST_LDWAIT;
          end else if (bus.Branch) begin
            r_pc <= w_taken ? w_target : w_pc_inc;
          end else begin
            if (w_op == OP_CMP) begin
              r_eq_f <= bus.AluEq;
              r_gt_f <= bus.AluGt;
              r_lt_f <= bus.AluLt;
            end
            r_pc <= w_pc_inc;
          end
        end

        ST_LDWAIT: begin
          r_state <= ST_RUN;
          r_pc    <= w_pc_inc;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ProgCtr   = r_pc;
  assign bus.ExecEn    = w_exec_en;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.InstCount = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural ROM and decoder feed the
// DUT from ProgCtr; outputs are checked on the falling edge.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  logic hb_force;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [8:0] rom  [1024];
  logic [8:0] rom4 [16];
  logic [3:0] op_m;
  logic [3:0] op_s;

  fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus  ();
  fetch_sequencer_if #(.PC_W(4),  .CNT_W(16)) bus4 ();

  fetch_sequencer #(.PC_W(10), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  fetch_sequencer #(.PC_W(4), .CNT_W(16)) dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus4)
  );

  always #5 Clk = ~Clk;

  // ROM read and decode for the 10-bit instance
  assign bus.Inst     = rom[bus.ProgCtr];
  assign op_m         = bus.Inst[8:5];
  assign bus.Branch   = (op_m >= 4'b1001) && (op_m <= 4'b1100);
  assign bus.Halt     = (op_m == 4'b1111);
  assign bus.MemToReg = (op_m == 4'b1110);

  // ROM read and decode for the 4-bit instance; hb_force presents an illegal
  // decode with Halt and Branch (BR to lut[3]) both asserted
  assign bus4.Inst     = hb_force ? {4'b1100, 5'd3} : rom4[bus4.ProgCtr];
  assign op_s          = bus4.Inst[8:5];
  assign bus4.Branch   = ((op_s >= 4'b1001) && (op_s <= 4'b1100)) | hb_force;
  assign bus4.Halt     = (op_s == 4'b1111) | hb_force;
  assign bus4.MemToReg = (op_s == 4'b1110);

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] arg);
    return {op, arg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input int pc, input logic ex,
                    input logic bz, input logic dn);
    chk({tag, ".pc"},   32'(bus.ProgCtr), 32'(pc));
    chk({tag, ".exec"}, 32'(bus.ExecEn),  32'(ex));
    chk({tag, ".busy"}, 32'(bus.Busy),    32'(bz));
    chk({tag, ".done"}, 32'(bus.Done),    32'(dn));
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic launch();
    bus.Start = 1'b1;
    ticks(1);
    bus.Start = 1'b0;
  endtask

  initial begin
    bus.Start  = 1'b0;
    bus.AluEq  = 1'b0;
    bus.AluGt  = 1'b0;
    bus.AluLt  = 1'b0;
    bus4.Start = 1'b0;
    bus4.AluEq = 1'b0;
    bus4.AluGt = 1'b0;
    bus4.AluLt = 1'b0;
    hb_force   = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    for (int i = 0; i < 16; i++) rom4[i] = 9'h000;

    // reset state
    ticks(1);
    st("rst", 0, 1'b0, 1'b0, 1'b0);
    chk("rst.cnt", 32'(bus.InstCount), 32'd0);
    chk("rst4.pc", 32'(bus4.ProgCtr), 32'd0);
    Reset = 1'b0;
    ticks(1);
    st("idle", 0, 1'b0, 1'b0, 1'b0);

    // straight line: ADD 0..2, HALT at 3; Start pulsed mid-run is ignored
    rom[3] = mk(OP_HALT, 5'd0);
    launch();
    st("sl0", 0, 1'b1, 1'b1, 1'b0);
    ticks(1);
    st("sl1", 1, 1'b1, 1'b1, 1'b0);
    launch();
    st("sl2_ign_start", 2, 1'b1, 1'b1, 1'b0);
    ticks(1);
    st("sl3", 3, 1'b1, 1'b1, 1'b0);
    ticks(1);
    st("sl_halt", 3, 1'b0, 1'b0, 1'b1);
    chk("sl.cnt", 32'(bus.InstCount), 32'd4);
    ticks(1);
    st("sl_hold", 3, 1'b0, 1'b0, 1'b1);

    // LOAD stall at address 1, relaunched from HALTED
    rom[1] = mk(OP_LOAD, 5'd0);
    launch();
    st("ld0", 0, 1'b1, 1'b1, 1'b0);
    chk("ld0.cnt", 32'(bus.InstCount), 32'd0);
    ticks(1);
    st("ld_run", 1, 1'b0, 1'b1, 1'b0);
    chk("ld_run.cnt", 32'(bus.InstCount), 32'd1);
    ticks(1);
    st("ld_wait", 1, 1'b1, 1'b1, 1'b0);
    chk("ld_wait.cnt", 32'(bus.InstCount), 32'd1);
    ticks(1);
    st("ld2", 2, 1'b1, 1'b1, 1'b0);
    chk("ld2.cnt", 32'(bus.InstCount), 32'd2);
    ticks(2);
    st("ld_halt", 3, 1'b0, 1'b0, 1'b1);
    chk("ld.cnt", 32'(bus.InstCount), 32'd4);
    rom[1] = 9'h000;
    rom[3] = 9'h000;

    // reset asserted while in LDWAIT at address 5
    rom[5] = mk(OP_LOAD, 5'd0);
    rom[6] = mk(OP_HALT, 5'd0);
    launch();
    ticks(5);
    st("mr_ld", 5, 1'b0, 1'b1, 1'b0);
    ticks(1);
    st("mr_ldwait", 5, 1'b1, 1'b1, 1'b0);
    Reset = 1'b1;
    #1;
    st("mr_rst", 0, 1'b0, 1'b0, 1'b0);
    chk("mr_rst.cnt", 32'(bus.InstCount), 32'd0);
    ticks(1);
    Reset = 1'b0;
    launch();
    st("mr_go0", 0, 1'b1, 1'b1, 1'b0);
    ticks(1);
    st("mr_go1", 1, 1'b1, 1'b1, 1'b0);
    ticks(7);
    st("mr_halt", 6, 1'b0, 1'b0, 1'b1);
    chk("mr.cnt", 32'(bus.InstCount), 32'd7);
    rom[5] = 9'h000;
    rom[6] = 9'h000;

    // conditional branches; BEQ at 0 also probes flag clearing on launch
    rom[0]  = mk(OP_BEQ, 5'd3);
    rom[4]  = mk(OP_CMP, 5'd0);
    rom[5]  = mk(OP_BEQ, 5'd3);
    rom[6]  = mk(OP_HALT, 5'd0);
    rom[20] = mk(OP_HALT, 5'd0);
    rom[8]  = mk(OP_HALT, 5'd0);
    bus.AluEq = 1'b1;
    launch();
    ticks(1);
    chk("beq_a.pc1", 32'(bus.ProgCtr), 32'd1);
    ticks(4);
    st("beq_a.at5", 5, 1'b1, 1'b1, 1'b0);
    ticks(1);
    chk("beq_taken.pc", 32'(bus.ProgCtr), 32'd20);
    ticks(1);
    st("beq_a.halt", 20, 1'b0, 1'b0, 1'b1);
    chk("beq_a.cnt", 32'(bus.InstCount), 32'd7);

    bus.AluEq = 1'b0;
    launch();
    ticks(1);
    chk("relaunch_flags_clr.pc", 32'(bus.ProgCtr), 32'd1);
    ticks(4);
    chk("beq_b.pc5", 32'(bus.ProgCtr), 32'd5);
    ticks(1);
    chk("beq_nt.pc", 32'(bus.ProgCtr), 32'd6);
    ticks(1);
    st("beq_b.halt", 6, 1'b0, 1'b0, 1'b1);

    rom[5] = mk(OP_BGT, 5'd1);
    bus.AluGt = 1'b1;
    launch();
    ticks(5);
    chk("bgt.pc5", 32'(bus.ProgCtr), 32'd5);
    ticks(1);
    chk("bgt_taken.pc", 32'(bus.ProgCtr), 32'd8);
    ticks(1);
    st("bgt.halt", 8, 1'b0, 1'b0, 1'b1);
    chk("bgt.cnt", 32'(bus.InstCount), 32'd7);
    bus.AluGt = 1'b0;

    // 4-bit PC wrap, then illegal Halt+Branch decode
    bus4.Start = 1'b1;
    ticks(1);
    bus4.Start = 1'b0;
    chk("w.pc0", 32'(bus4.ProgCtr), 32'd0);
    ticks(15);
    chk("w.pc15", 32'(bus4.ProgCtr), 32'd15);
    ticks(1);
    chk("wrap.pc", 32'(bus4.ProgCtr), 32'd0);
    chk("wrap.busy", 32'(bus4.Busy), 32'd1);
    chk("wrap.cnt", 32'(bus4.InstCount), 32'd16);
    ticks(1);
    hb_force = 1'b1;
    #1;
    chk("hb.exec", 32'(bus4.ExecEn), 32'd1);
    ticks(1);
    chk("hb.pc_held", 32'(bus4.ProgCtr), 32'd1);
    chk("hb.done", 32'(bus4.Done), 32'd1);
    chk("hb.busy", 32'(bus4.Busy), 32'd0);
    hb_force = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
